// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'b00,
    WAIT  = 2'b01,
    HOLD  = 2'b10,
    FAULT = 2'b11
  } fetch_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_BUS      = 2'b01,
    FC_TIMEOUT  = 2'b10,
    FC_MISALIGN = 2'b11
  } fault_cause_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting for an imem response; expired is high on the
// last permitted cycle (count == TIMEOUT_CYCLES-1).
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  // Clear has priority over counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, runs the imem req/gnt/rvalid handshake and
// holds each fetched word for the decoder until it is accepted.
// Optional build macro: FETCH_MISALIGN_TRAP_EN (misaligned redirects trap
// with cause 11 instead of having the low address bits cleared).
//
// Handshakes: imem_req is held with a stable imem_addr until imem_gnt is
// seen with imem_req high; instr_valid/instruction/instr_pc stay stable
// until instr_ready is seen with instr_valid high. A redirect overrides both.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_err,
  output logic         instr_valid,
  output logic [31:0]  instruction,
  output logic [31:0]  instr_pc,
  input  logic         instr_ready,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         fetch_fault,
  output logic [1:0]   fault_cause,
  output fetch_state_t fsm_state
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic         squash, squash_n;
  logic         imem_req_n;
  logic         instr_valid_n;
  logic [31:0]  instruction_n;
  logic [31:0]  instr_pc_n;
  logic         fault_n;
  fault_cause_t cause_n;
  logic         req_accept;
  logic         expired;
  logic [31:0]  redir_pc;
  logic         misalign;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_pc = redirect_pc;
  assign misalign = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc = redirect_pc & ~32'h3;
  assign misalign = 1'b0;
`endif

  assign req_accept = imem_req & imem_gnt;
  assign imem_addr  = pc;
  assign fsm_state  = state;

  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != WAIT),
    .enable (state == WAIT),
    .expired(expired)
  );

  // Next-state and next-output logic; redirect wins over everything else.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    squash_n      = squash;
    instr_valid_n = instr_valid;
    instruction_n = instruction;
    instr_pc_n    = instr_pc;
    fault_n       = fetch_fault;
    cause_n       = fault_cause_t'(fault_cause);

    case (state)
      REQ: begin
        if (redirect_valid) begin
          pc_n = redir_pc;
          if (req_accept) begin
            // Request already left; its response must be discarded.
            state_n  = WAIT;
            squash_n = 1'b1;
          end else if (misalign) begin
            state_n    = FAULT;
            instr_pc_n = redir_pc;
            fault_n    = 1'b1;
            cause_n    = FC_MISALIGN;
          end
        end else if (req_accept) begin
          state_n = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_n = redir_pc;
        end
        if (redirect_valid || squash) begin
          if (imem_rvalid || expired) begin
            // Stale response or timeout dropped silently.
            squash_n = 1'b0;
            state_n  = REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (pc_n[1:0] != 2'b00) begin
              state_n    = FAULT;
              instr_pc_n = pc_n;
              fault_n    = 1'b1;
              cause_n    = FC_MISALIGN;
            end
`endif
          end else begin
            squash_n = 1'b1;
          end
        end else if (imem_rvalid && !imem_err) begin
          state_n       = HOLD;
          instruction_n = imem_rdata;
          instr_pc_n    = pc;
          instr_valid_n = 1'b1;
        end else if (imem_rvalid && imem_err) begin
          state_n = FAULT;
          fault_n = 1'b1;
          cause_n = FC_BUS;
        end else if (expired) begin
          state_n = FAULT;
          fault_n = 1'b1;
          cause_n = FC_TIMEOUT;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          // Redirect beats a simultaneous instr_ready: no sequential step.
          instr_valid_n = 1'b0;
          pc_n          = redir_pc;
          state_n       = REQ;
          if (misalign) begin
            state_n    = FAULT;
            instr_pc_n = redir_pc;
            fault_n    = 1'b1;
            cause_n    = FC_MISALIGN;
          end
        end else if (instr_ready) begin
          instr_valid_n = 1'b0;
          pc_n          = next_pc(pc);
          state_n       = REQ;
        end
      end

      FAULT: begin
        if (redirect_valid) begin
          pc_n = redir_pc;
          if (misalign) begin
            instr_pc_n = redir_pc;
            fault_n    = 1'b1;
            cause_n    = FC_MISALIGN;
          end else begin
            fault_n = 1'b0;
            cause_n = FC_NONE;
            state_n = REQ;
          end
        end
      end
    endcase

    imem_req_n = (state_n == REQ);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= REQ;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      instr_pc    <= 32'h0;
      fetch_fault <= 1'b0;
      fault_cause <= FC_NONE;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      squash      <= squash_n;
      imem_req    <= imem_req_n;
      instr_valid <= instr_valid_n;
      instruction <= instruction_n;
      instr_pc    <= instr_pc_n;
      fetch_fault <= fault_n;
      fault_cause <= cause_n;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: table of fetch vectors plus hand-written
// redirect, fault, wrap and reset sequences. Build with
// FETCH_MISALIGN_TRAP_EN defined to exercise the trap variant.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt = 1'b0;
  logic         imem_rvalid = 1'b0;
  logic [31:0]  imem_rdata = '0;
  logic         imem_err = 1'b0;
  logic         instr_valid;
  logic [31:0]  instruction;
  logic [31:0]  instr_pc;
  logic         instr_ready = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic         fetch_fault;
  logic [1:0]   fault_cause;
  fetch_state_t fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  bit stale_seen = 1'b0;

  typedef struct {
    int unsigned gnt_dly;
    int unsigned rsp_dly;
    logic [31:0] rdata;
    int unsigned rdy_dly;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  fetch_sequencer #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .imem_err      (imem_err),
    .instr_valid   (instr_valid),
    .instruction   (instruction),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_fault   (fetch_fault),
    .fault_cause   (fault_cause),
    .fsm_state     (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watch for a squashed word ever reaching the decoder
  always @(negedge clk) begin
    if (instr_valid && instruction == 32'hDEAD_BEEF) stale_seen = 1'b1;
  end

  // Hard stop if something hangs outright
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int i;
    for (i = 0; i < 40; i++) begin
      if (imem_req) break;
      tick();
    end
    check({tag, "_req_seen"}, {31'b0, imem_req}, 32'd1);
  endtask

  // Pop the scoreboard once the decoder side shows a valid word
  task automatic sb_compare(input string tag);
    logic [63:0] e;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) break;
      tick();
    end
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_sb_empty: got empty queue required one entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_instr_pc"}, instr_pc, e[63:32]);
      check({tag, "_instruction"}, instruction, e[31:0]);
    end
  endtask

  // One full fetch; with accept=0 it returns leaving the word in HOLD
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr,
                          input int unsigned gnt_dly, input int unsigned rsp_dly,
                          input logic [31:0] rdata, input int unsigned rdy_dly,
                          input bit accept);
    bit stable;
    logic [31:0] held_i, held_pc;
    wait_req(tag);
    check({tag, "_addr"}, imem_addr, exp_addr);
    stable = 1'b1;
    for (int i = 0; i < int'(gnt_dly); i++) begin
      tick();
      if (!imem_req || imem_addr !== exp_addr) stable = 1'b0;
    end
    check({tag, "_req_stable"}, {31'b0, stable}, 32'd1);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check({tag, "_req_drop"}, {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < int'(rsp_dly); i++) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = rdata;
    imem_err    = 1'b0;
    exp_q.push_back({exp_addr, rdata});
    tick();
    imem_rvalid = 1'b0;
    sb_compare(tag);
    if (accept) begin
      held_i  = instruction;
      held_pc = instr_pc;
      stable  = 1'b1;
      for (int i = 0; i < int'(rdy_dly); i++) begin
        tick();
        if (!instr_valid || imem_req || instruction !== held_i || instr_pc !== held_pc)
          stable = 1'b0;
      end
      check({tag, "_hold_stable"}, {31'b0, stable}, 32'd1);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'b0, instr_valid}, 32'd0);
    end
  endtask

  initial begin
    // Vector table: random handshake delays, expected sequential PCs
    for (int i = 0; i < 6; i++) begin
      vecs[i].gnt_dly  = $urandom_range(0, 2);
      vecs[i].rsp_dly  = $urandom_range(0, 3);
      vecs[i].rdata    = $urandom;
      vecs[i].rdy_dly  = (i == 2) ? 5 : $urandom_range(0, 2);
      vecs[i].exp_addr = 32'(i * 4);
    end
    if (vecs[0].rdata == 32'hDEAD_BEEF) vecs[0].rdata = 32'h1234_5678;

    // Reset values
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instruction", instruction, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    check("rst_cause", {30'b0, fault_cause}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_state", {30'b0, fsm_state}, {30'b0, REQ});
    rst_n = 1'b1;

    // Table-driven sequential fetches (first one is the 0x0 / 0x4 case)
    for (int i = 0; i < 6; i++) begin
      do_fetch($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].gnt_dly,
               vecs[i].rsp_dly, vecs[i].rdata, vecs[i].rdy_dly, 1'b1);
    end

    // Redirect while in WAIT: stale word dropped, next fetch at 0x100
    wait_req("rdw");
    check("rdw_addr", imem_addr, 32'h18);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("rdw_no_req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("rdw_valid_low", {31'b0, instr_valid}, 32'd0);
    check("rdw_new_addr", imem_addr, 32'h100);
    do_fetch("rdw_f", 32'h100, 0, 1, 32'hA5A5_0100, 0, 1'b1);

    // Bus error: sticky fault, then redirect to 0x200 clears it
    wait_req("err");
    check("err_addr", imem_addr, 32'h104);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_err    = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    check("err_fault", {31'b0, fetch_fault}, 32'd1);
    check("err_cause", {30'b0, fault_cause}, 32'd1);
    check("err_valid", {31'b0, instr_valid}, 32'd0);
    repeat (3) tick();
    check("err_sticky", {31'b0, fetch_fault}, 32'd1);
    check("err_no_req", {31'b0, imem_req}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("err_clr_fault", {31'b0, fetch_fault}, 32'd0);
    check("err_clr_cause", {30'b0, fault_cause}, 32'd0);
    check("err_clr_req", {31'b0, imem_req}, 32'd1);
    check("err_clr_addr", imem_addr, 32'h200);

    // Timeout: 16 WAIT cycles with no response
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    repeat (15) tick();
    check("to_not_yet", {31'b0, fetch_fault}, 32'd0);
    tick();
    check("to_fault", {31'b0, fetch_fault}, 32'd1);
    check("to_cause", {30'b0, fault_cause}, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_valid = 1'b0;
    check("to_clr_addr", imem_addr, 32'h300);

    // Redirect in the same cycle as the grant: response squashed
    imem_gnt       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    tick();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b0;
    check("rgnt_no_req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("rgnt_req", {31'b0, imem_req}, 32'd1);
    check("rgnt_addr", imem_addr, 32'h400);

    // Misaligned redirect together with instr_ready in HOLD
    do_fetch("mis_f", 32'h400, 1, 0, 32'h0BAD_F00D, 0, 1'b0);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    check("mis_valid", {31'b0, instr_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_fault", {31'b0, fetch_fault}, 32'd1);
    check("mis_cause", {30'b0, fault_cause}, 32'd3);
    check("mis_instr_pc", instr_pc, 32'h102);
    tick();
    check("mis_no_req", {31'b0, imem_req}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("mis_clr_fault", {31'b0, fetch_fault}, 32'd0);
`else
    check("mis_fault", {31'b0, fetch_fault}, 32'd0);
    check("mis_req", {31'b0, imem_req}, 32'd1);
`endif
    check("mis_addr", imem_addr, 32'h100);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    do_fetch("wrap_f", 32'hFFFF_FFFC, 0, 0, 32'h7777_0001, 1, 1'b1);
    wait_req("wrap");
    check("wrap_addr", imem_addr, 32'h0);

    // Reset mid-transaction discards the outstanding response
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst_n    = 1'b0;
    tick();
    check("mrst_req", {31'b0, imem_req}, 32'd0);
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("mrst_valid", {31'b0, instr_valid}, 32'd0);
    check("mrst_addr", imem_addr, 32'h0);
    do_fetch("mrst_f", 32'h0, 0, 2, 32'h5555_AAAA, 0, 1'b1);

    tick();
    check("stale_never_seen", {31'b0, stale_seen}, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
